// File: rtl/rst_seq.sv
// Reset sequencer: holds all reset lines high, then releases them one by one
// (bit 0 first) with a fixed hold window and stagger. A req restarts the sequence.
module rst_seq #(
    parameter int NR_OUT      = 3,
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic [NR_OUT-1:0] rst_out,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(NR_OUT) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NR_OUT - 1);
    localparam logic [NR_OUT-1:0] ONE_HOT0 = NR_OUT'(1);

    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [NR_OUT-1:0] out_nxt;
    logic              done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= '1;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            rst_out <= out_nxt;
            done    <= done_nxt;
        end
    end

    // req takes priority over any release, including the final one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        out_nxt   = rst_out;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                out_nxt = '0;
                if (req) begin
                    out_nxt   = '1;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (req) begin
                    out_nxt = '1;
                    cnt_nxt = '0;
                    idx_nxt = '0;
                end else if (cnt == HOLD_LAST) begin
                    out_nxt = rst_out & ~ONE_HOT0;
                    cnt_nxt = '0;
                    idx_nxt = IDX_W'(1);
                    if (NR_OUT == 1) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (req) begin
                    out_nxt   = '1;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = ASSERT;
                end else if (cnt == STAG_LAST) begin
                    out_nxt = rst_out & ~(ONE_HOT0 << idx);
                    cnt_nxt = '0;
                    idx_nxt = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ASSERT;
                out_nxt   = '1;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: default configuration and a 1-output/1-cycle-hold
// configuration, both driven from one stimulus stream and checked against a timeline model.
module tb_rst_seq;

    localparam int NR0 = 3, H0 = 16, S0 = 4;
    localparam int NR1 = 1, H1 = 1,  S1 = 4;

    logic       clk = 1'b0;
    logic       rst, req0, req1;
    logic [2:0] rst_out0;
    logic [0:0] rst_out1;
    logic       busy0, done0, busy1, done1;

    typedef struct packed {
        logic [7:0] o;
        logic       b;
        logic       d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   act[2];
    int   tt[2];
    int   nchk  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    rst_seq #(.NR_OUT(NR0), .HOLD_CYC(H0), .STAGGER_CYC(S0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .req(req0), .rst_out(rst_out0), .busy(busy0), .done(done0)
    );

    rst_seq #(.NR_OUT(NR1), .HOLD_CYC(H1), .STAGGER_CYC(S1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .req(req1), .rst_out(rst_out1), .busy(busy1), .done(done1)
    );

    // Model: tt counts edges since the sequence (re)started; output k is low once
    // tt reaches hold + k*stagger, and the sequence ends when the last one falls.
    function automatic exp_t mstep(input int id, input bit r, input bit rs,
                                   input int nr, input int hold, input int stag);
        exp_t e;
        e = '0;
        if (rs) begin
            act[id] = 1'b1;
            tt[id]  = 0;
        end else if (!act[id]) begin
            if (r) begin
                act[id] = 1'b1;
                tt[id]  = 0;
            end
        end else if (r) begin
            tt[id] = 0;
        end else begin
            tt[id]++;
            if (tt[id] >= hold + (nr - 1) * stag) begin
                act[id] = 1'b0;
                e.d     = 1'b1;
            end
        end
        e.b = act[id];
        for (int k = 0; k < nr; k++)
            e.o[k] = act[id] && (tt[id] < hold + k * stag);
        return e;
    endfunction

    task automatic edge_step(input bit r0, input bit r1);
        req0 = r0;
        req1 = r1;
        @(posedge clk);
        q0.push_back(mstep(0, r0, rst, NR0, H0, S0));
        q1.push_back(mstep(1, r1, rst, NR1, H1, S1));
        #1;
    endtask

    task automatic async_rst_check();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        nchk++;
        if ({rst_out0, busy0, done0} !== {3'b111, 1'b1, 1'b0}) begin
            nfail++;
            $display("FAIL async_rst u0: rst_out=%b busy=%b done=%b, required rst_out=111 busy=1 done=0",
                     rst_out0, busy0, done0);
        end
        nchk++;
        if ({rst_out1, busy1, done1} !== {1'b1, 1'b1, 1'b0}) begin
            nfail++;
            $display("FAIL async_rst u1: rst_out=%b busy=%b done=%b, required rst_out=1 busy=1 done=0",
                     rst_out1, busy1, done1);
        end
        edge_step(1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                nchk++;
                if ({rst_out0, busy0, done0} !== {e.o[2:0], e.b, e.d}) begin
                    nfail++;
                    $display("FAIL seq u0 @%0t: rst_out=%b busy=%b done=%b, required rst_out=%b busy=%b done=%b",
                             $time, rst_out0, busy0, done0, e.o[2:0], e.b, e.d);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                nchk++;
                if ({rst_out1, busy1, done1} !== {e.o[0], e.b, e.d}) begin
                    nfail++;
                    $display("FAIL seq u1 @%0t: rst_out=%b busy=%b done=%b, required rst_out=%b busy=%b done=%b",
                             $time, rst_out1, busy1, done1, e.o[0], e.b, e.d);
                end
            end
        end
    end

    initial begin : driver
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) edge_step(1'b0, 1'b0);
        rst = 1'b0;

        // power-up sequence
        repeat (30) edge_step(1'b0, 1'b0);
        // single req from IDLE
        edge_step(1'b1, 1'b0);
        repeat (30) edge_step(1'b0, 1'b0);
        // req on the 10th ASSERT edge restarts the hold
        edge_step(1'b1, 1'b0);
        repeat (9) edge_step(1'b0, 1'b0);
        edge_step(1'b1, 1'b0);
        repeat (30) edge_step(1'b0, 1'b0);
        // req two edges after bit 0 released
        edge_step(1'b1, 1'b0);
        repeat (17) edge_step(1'b0, 1'b0);
        edge_step(1'b1, 1'b0);
        repeat (30) edge_step(1'b0, 1'b0);
        // req coincident with the final release
        edge_step(1'b1, 1'b0);
        repeat (23) edge_step(1'b0, 1'b0);
        edge_step(1'b1, 1'b0);
        repeat (30) edge_step(1'b0, 1'b0);
        // req during the done cycle
        edge_step(1'b1, 1'b0);
        repeat (24) edge_step(1'b0, 1'b0);
        edge_step(1'b1, 1'b0);
        repeat (30) edge_step(1'b0, 1'b0);
        // asynchronous reset mid-RELEASE
        edge_step(1'b1, 1'b0);
        repeat (18) edge_step(1'b0, 1'b0);
        async_rst_check();
        rst = 1'b0;
        repeat (30) edge_step(1'b0, 1'b0);
        // held req on the single-output instance
        repeat (20) edge_step(1'b0, 1'b1);
        repeat (5) edge_step(1'b0, 1'b0);
        // random req traffic
        repeat (500) edge_step($urandom_range(0, 30) == 0, $urandom_range(0, 5) == 0);
        repeat (30) edge_step(1'b0, 1'b0);

        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
